// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one trial subtraction per cycle, MSB first.
// Optional macro ALU_DIV_ZERO_TRAP_EN: short-circuits b==0 to a one-edge result with dz=1.
module alu_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
`ifdef ALU_DIV_ZERO_TRAP_EN
    logic             dz_pend_q, dz_pend_d;
`endif

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            r_q       <= '0;
            q_q       <= '0;
            dvsr_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
`ifdef ALU_DIV_ZERO_TRAP_EN
            dz_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            r_q       <= r_d;
            q_q       <= q_d;
            dvsr_q    <= dvsr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
`ifdef ALU_DIV_ZERO_TRAP_EN
            dz_pend_q <= dz_pend_d;
`endif
        end
    end

    // The most negative value maps to itself under negation, which is its correct unsigned magnitude.
    assign a_mag   = (sign && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (sign && b[WIDTH-1]) ? -b : b;
    assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        r_d       = r_q;
        q_d       = q_q;
        dvsr_d    = dvsr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
`ifdef ALU_DIV_ZERO_TRAP_EN
        dz_pend_d = dz_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvsr_d    = b_mag;
                    q_d       = a_mag;
                    r_d       = '0;
                    count_d   = '0;
                    neg_quo_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sign & a[WIDTH-1];
                    state_d   = RUN;
`ifdef ALU_DIV_ZERO_TRAP_EN
                    dz_pend_d = 1'b0;
                    // Preload so the FIX step yields quo=0 and rem=a without a separate path.
                    if (b == '0) begin
                        dz_pend_d = 1'b1;
                        q_d       = '0;
                        r_d       = {1'b0, a_mag};
                        neg_quo_d = 1'b0;
                        state_d   = FIX;
                    end
`endif
                end
            end
            RUN: begin
                q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                r_d     = trial[WIDTH] ? shifted : trial;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = neg_quo_q ? -q_q : q_q;
                rem_d   = neg_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                done_d  = 1'b1;
`ifdef ALU_DIV_ZERO_TRAP_EN
                dz_d    = dz_pend_q;
`else
                dz_d    = 1'b0;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: expected results queued at issue, compared at done.
module tb_alu_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;

    alu_div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .quo   (quo),
        .rem   (rem),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dz;
        int           lat;
        int           issued;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sign;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W-1:0] int_min;
        int_min  = {1'b1, {(W-1){1'b0}}};
        e.dz     = 1'b0;
        e.lat    = W + 1;
        e.issued = 0;
        e.a      = x;
        e.b      = y;
        e.sign   = s;
        if (y == '0) begin
`ifdef ALU_DIV_ZERO_TRAP_EN
            e.quo = '0;
            e.rem = x;
            e.dz  = 1'b1;
            e.lat = 1;
`else
            e.quo = (s && x[W-1]) ? W'(1) : '1;
            e.rem = x;
`endif
        end else if (s && x == int_min && y == '1) begin
            e.quo = int_min;
            e.rem = '0;
        end else if (s) begin
            e.quo = $signed(x) / $signed(y);
            e.rem = $signed(x) % $signed(y);
        end else begin
            e.quo = x / y;
            e.rem = x % y;
        end
        return e;
    endfunction

    // Drives start for one edge; caller positions the call away from posedge.
    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        exp_t e;
        start = 1'b1;
        sign  = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        sign  = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (push) begin
            e        = model(s, x, y);
            e.issued = cyc;
            sb.push_back(e);
            chk("busy_after_start", {31'b0, busy}, 1);
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'b0, done}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %s a=0x%08h b=0x%08h -> quo=0x%08h rem=0x%08h dz=%0b lat=%0d",
                         e.sign ? "DIV " : "DIVU", e.a, e.b, quo, rem, dz, cyc - e.issued);
                chk("quo", quo, e.quo);
                chk("rem", rem, e.rem);
                chk("dz", {31'b0, dz}, {31'b0, e.dz});
                chk("latency", W'(cyc - e.issued), W'(e.lat));
                chk("busy_low_at_done", {31'b0, busy}, 0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_quo", quo, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dz", {31'b0, dz}, 0);
        reset = 1'b0;

        // Basic unsigned, signed signs, overflow and all-ones cases issued back-to-back.
        @(negedge clk);
        issue(0, 100, 7, 1);
        wait_done(40);
        issue(1, 32'hFFFF_FFF9, 2, 1);
        wait_done(40);
        issue(1, 7, 32'hFFFF_FFFE, 1);
        wait_done(40);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(40);
        issue(0, 32'hFFFF_FFFF, 1, 1);
        wait_done(40);

        // Divide by zero, unsigned and signed-negative dividend.
        issue(0, 32'h1234_5678, 0, 1);
        wait_done(40);
        issue(1, 32'h8765_4321, 0, 1);
        wait_done(40);

        // A start during a running divide is ignored; re-issue in the done cycle.
        @(negedge clk);
        issue(0, 100, 7, 1);
        repeat (9) @(negedge clk);
        issue(0, 50, 5, 0);
        wait_done(40);
        issue(0, 50, 5, 1);
        wait_done(40);

        // Reset mid-operation abandons the divide and clears outputs at once.
        @(negedge clk);
        issue(0, 100, 7, 1);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_quo", quo, 0);
        chk("midrst_rem", rem, 0);
        chk("midrst_dz", {31'b0, dz}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(1, 32'hFFFF_FF9C, 7, 1);
        wait_done(40);

        // Random mix, issued back-to-back.
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 100));
            issue(1'($urandom), ra, rb, 1);
            wait_done(40);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", W'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
